issue_hazard_ctrl: RTL and testbench

- Stall/flush sequencer for the dual-issue pipeline: pipe 1 is the ALU pipe, pipe 2 is the memory pipe. Register addresses are 3 bits; r0 is never a hazard source.
- Sits beside the ID stage. Covers the hazards that operand forwarding cannot resolve:
  - load-use on a pipe-2 load;
  - intra-pair RAW, where slot 2 reads slot 1's destination;
  - taken-branch flush from EX.
- Drives PC/IF-ID write enables, ID/EX bubble inserts and the IF/ID split/flush controls.

---
 rtl/issue_hazard_ctrl_if.sv | 36 +++
 rtl/issue_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_issue_hazard_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_hazard_ctrl_if.sv
// ID-stage hazard bundle: decode/EX hazard sources in, pipeline enables and bubble/flush controls out.
// Pure wiring; the controller behind the slave modport decides the controls in the same cycle.
interface issue_hazard_ctrl_if #(
  parameter int REG_AW = 3
);
  logic              id_valid1;
  logic              id_valid2;
  logic [REG_AW-1:0] id_rm_1;
  logic [REG_AW-1:0] id_rn_1;
  logic [REG_AW-1:0] id_rd_1;
  logic              id_wr_1;
  logic [REG_AW-1:0] id_rm_2;
  logic [REG_AW-1:0] id_rn_2;
  logic              ex_load2;
  logic [REG_AW-1:0] ex_rd_2;
  logic              ex_branch_taken;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              split_hold;
  logic              bubble1;
  logic              bubble2;
  logic [1:0]        state;

  modport master (
    output id_valid1, id_valid2, id_rm_1, id_rn_1, id_rd_1, id_wr_1,
           id_rm_2, id_rn_2, ex_load2, ex_rd_2, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, split_hold, bubble1, bubble2, state
  );

  modport slave (
    input  id_valid1, id_valid2, id_rm_1, id_rn_1, id_rd_1, id_wr_1,
           id_rm_2, id_rn_2, ex_load2, ex_rd_2, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, split_hold, bubble1, bubble2, state
  );
endinterface

// File: rtl/issue_hazard_ctrl.sv
// Dual-issue stall/flush sequencer (load-use, intra-pair RAW, taken branch); HAZARD_STATS_EN adds cycle counters.
// Zero-latency Mealy controls in the detection cycle, Moore afterwards; backpressure is pc_write/if_id_write low.
module issue_hazard_ctrl #(
  parameter int REG_AW    = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef HAZARD_STATS_EN
  input  logic               stats_clr,
  output logic [15:0]        stall_cycles,
  output logic [15:0]        flush_cycles,
`endif
  issue_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    SPLIT  = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  localparam logic [2:0] LL_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FC_RELOAD = 3'(FLUSH_CYC - 1);

  state_e            r_state;
  state_e            w_nxt_state;
  logic [2:0]        r_cnt;
  logic [2:0]        w_nxt_cnt;
  logic [2:0]        w_cnt_dec;
  logic [REG_AW-1:0] w_ld_rd;
  logic              w_ld_live;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_lu_run;
  logic              w_lu_split;
  logic              w_raw;
  logic              w_pc_write;
  logic              w_if_id_write;
  logic              w_if_id_flush;
  logic              w_split_hold;
  logic              w_bubble1;
  logic              w_bubble2;

  // r0 is hardwired zero, so a load targeting it can never create a dependency
  assign w_ld_rd    = hz.ex_rd_2;
  assign w_ld_live  = hz.ex_load2 && (w_ld_rd != '0);
  assign w_hit1     = hz.id_valid1 && ((hz.id_rm_1 == w_ld_rd) || (hz.id_rn_1 == w_ld_rd));
  assign w_hit2     = hz.id_valid2 && ((hz.id_rm_2 == w_ld_rd) || (hz.id_rn_2 == w_ld_rd));
  assign w_lu_run   = w_ld_live && (w_hit1 || w_hit2);
  assign w_lu_split = w_ld_live && w_hit2;
  assign w_raw      = hz.id_valid1 && hz.id_valid2 && hz.id_wr_1 && (hz.id_rd_1 != '0) &&
                      ((hz.id_rm_2 == hz.id_rd_1) || (hz.id_rn_2 == hz.id_rd_1));
  assign w_cnt_dec  = (r_cnt == 3'd0) ? 3'd0 : (r_cnt - 3'd1);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_split_hold  = 1'b0;
    w_bubble1     = 1'b0;
    w_bubble2     = 1'b0;

    if (hz.ex_branch_taken) begin
      // a taken branch wins from every state, including a flush already in progress
      w_if_id_flush = 1'b1;
      w_bubble1     = 1'b1;
      w_bubble2     = 1'b1;
      if (FLUSH_CYC > 1) begin
        w_nxt_state = FLUSH;
        w_nxt_cnt   = FC_RELOAD;
      end else begin
        w_nxt_state = RUN;
        w_nxt_cnt   = 3'd0;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_lu_run) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble1     = 1'b1;
            w_bubble2     = 1'b1;
            if (LOAD_LAT > 1) begin
              w_nxt_state = LSTALL;
              w_nxt_cnt   = LL_RELOAD;
            end
          end else if (w_raw) begin
            w_split_hold = 1'b1;
            w_pc_write   = 1'b0;
            w_bubble2    = 1'b1;
            w_nxt_state  = SPLIT;
          end
        end
        LSTALL, FLUSH: begin
          if (r_state == LSTALL) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
          end else begin
            w_if_id_flush = 1'b1;
          end
          w_bubble1 = 1'b1;
          w_bubble2 = 1'b1;
          w_nxt_cnt = w_cnt_dec;
          if (w_cnt_dec == 3'd0) begin
            w_nxt_state = RUN;
          end
        end
        SPLIT: begin
          // slot 1 already issued alone, only slot 2 can still be a load consumer
          if (w_lu_split) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble1     = 1'b1;
            w_bubble2     = 1'b1;
            if (LOAD_LAT > 1) begin
              w_nxt_state = LSTALL;
              w_nxt_cnt   = LL_RELOAD;
            end else begin
              w_nxt_state = RUN;
            end
          end else begin
            w_bubble1   = 1'b1;
            w_nxt_state = RUN;
          end
        end
        default: begin
          w_nxt_state = RUN;
          w_nxt_cnt   = 3'd0;
        end
      endcase
    end

    // while reset is held the controls must read as pass-through regardless of inputs
    if (!rst_n) begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_if_id_flush = 1'b0;
      w_split_hold  = 1'b0;
      w_bubble1     = 1'b0;
      w_bubble2     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  assign hz.pc_write    = w_pc_write;
  assign hz.if_id_write = w_if_id_write;
  assign hz.if_id_flush = w_if_id_flush;
  assign hz.split_hold  = w_split_hold;
  assign hz.bubble1     = w_bubble1;
  assign hz.bubble2     = w_bubble2;
  assign hz.state       = r_state;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
      r_flush_cycles <= 16'd0;
    end else if (stats_clr) begin
      r_stall_cycles <= 16'd0;
      r_flush_cycles <= 16'd0;
    end else begin
      if (!w_pc_write && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_if_id_flush && (r_flush_cycles != 16'hFFFF)) begin
        r_flush_cycles <= r_flush_cycles + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Bench for issue_hazard_ctrl: three parameterisations share one stimulus stream.
// Directed table, reset/stats sequences, then random traffic against a counter-based reference model.
module tb_issue_hazard_ctrl;

  typedef struct packed {
    logic       v1;
    logic       v2;
    logic [2:0] rm1;
    logic [2:0] rn1;
    logic [2:0] rd1;
    logic       wr1;
    logic [2:0] rm2;
    logic [2:0] rn2;
    logic       ld;
    logic [2:0] exrd;
    logic       br;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ec;
  } vec_t;

  typedef struct {
    int stall_left;
    int flush_left;
    bit split;
  } mst_t;

  localparam int LLV [3] = '{1, 2, 3};
  localparam int FCV [3] = '{1, 3, 2};

  logic       clk;
  logic       rst_n;
  stim_t      cur;
  logic [7:0] obs  [3];
  logic [7:0] mexp [3];
  mst_t       m    [3];
  int         checks;
  int         fails;

`ifdef HAZARD_STATS_EN
  logic        stats_clr;
  logic [15:0] st_stall [3];
  logic [15:0] st_flush [3];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    issue_hazard_ctrl_if #(.REG_AW(3)) ifc ();
    assign ifc.id_valid1       = cur.v1;
    assign ifc.id_valid2       = cur.v2;
    assign ifc.id_rm_1         = cur.rm1;
    assign ifc.id_rn_1         = cur.rn1;
    assign ifc.id_rd_1         = cur.rd1;
    assign ifc.id_wr_1         = cur.wr1;
    assign ifc.id_rm_2         = cur.rm2;
    assign ifc.id_rn_2         = cur.rn2;
    assign ifc.ex_load2        = cur.ld;
    assign ifc.ex_rd_2         = cur.exrd;
    assign ifc.ex_branch_taken = cur.br;

    issue_hazard_ctrl #(
      .REG_AW   (3),
      .LOAD_LAT (g == 0 ? 1 : (g == 1 ? 2 : 3)),
      .FLUSH_CYC(g == 0 ? 1 : (g == 1 ? 3 : 2))
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef HAZARD_STATS_EN
      .stats_clr   (stats_clr),
      .stall_cycles(st_stall[g]),
      .flush_cycles(st_flush[g]),
`endif
      .hz          (ifc)
    );

    assign obs[g] = {ifc.state, ifc.pc_write, ifc.if_id_write, ifc.if_id_flush,
                     ifc.split_hold, ifc.bubble1, ifc.bubble2};
  end

  function automatic stim_t mks(bit v1, bit v2, int rm1, int rn1, int rd1, bit wr1,
                                int rm2, int rn2, bit ld, int exrd, bit br);
    stim_t s;
    s.v1 = v1;  s.v2 = v2;
    s.rm1 = 3'(rm1); s.rn1 = 3'(rn1); s.rd1 = 3'(rd1); s.wr1 = wr1;
    s.rm2 = 3'(rm2); s.rn2 = 3'(rn2);
    s.ld = ld; s.exrd = 3'(exrd); s.br = br;
    return s;
  endfunction

  function automatic bit lu_hit(stim_t s, bit use_slot1);
    bit h = 1'b0;
    if (!s.ld || s.exrd == 3'd0) return 1'b0;
    if (use_slot1 && s.v1 && (s.rm1 == s.exrd || s.rn1 == s.exrd)) h = 1'b1;
    if (s.v2 && (s.rm2 == s.exrd || s.rn2 == s.exrd)) h = 1'b1;
    return h;
  endfunction

  // Reference: remaining stall/flush cycle counts plus a pending-split flag.
  function automatic void mstep(input int ll, input int fc, input stim_t s,
                                inout mst_t ms, output logic [7:0] e);
    logic [1:0] st;
    bit pc, ifw, fl, sh, b1, b2;
    st = (ms.flush_left > 0) ? 2'd3 : (ms.stall_left > 0) ? 2'd1 : ms.split ? 2'd2 : 2'd0;
    pc = 1; ifw = 1; fl = 0; sh = 0; b1 = 0; b2 = 0;
    if (s.br) begin
      fl = 1; b1 = 1; b2 = 1;
      ms.flush_left = fc - 1; ms.stall_left = 0; ms.split = 0;
    end else if (ms.flush_left > 0) begin
      fl = 1; b1 = 1; b2 = 1;
      ms.flush_left--;
    end else if (ms.stall_left > 0) begin
      pc = 0; ifw = 0; b1 = 1; b2 = 1;
      ms.stall_left--;
    end else if (ms.split) begin
      ms.split = 0;
      if (lu_hit(s, 1'b0)) begin
        pc = 0; ifw = 0; b1 = 1; b2 = 1;
        ms.stall_left = ll - 1;
      end else begin
        b1 = 1;
      end
    end else if (lu_hit(s, 1'b1)) begin
      pc = 0; ifw = 0; b1 = 1; b2 = 1;
      ms.stall_left = ll - 1;
    end else if (s.v1 && s.v2 && s.wr1 && s.rd1 != 3'd0 && (s.rm2 == s.rd1 || s.rn2 == s.rd1)) begin
      pc = 0; sh = 1; b2 = 1;
      ms.split = 1;
    end
    e = {st, pc, ifw, fl, sh, b1, b2};
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.v1   = ($urandom_range(0, 9) < 7);
    s.v2   = ($urandom_range(0, 9) < 7);
    s.rm1  = 3'($urandom_range(0, 3));
    s.rn1  = 3'($urandom_range(0, 3));
    s.rd1  = 3'($urandom_range(0, 3));
    s.wr1  = ($urandom_range(0, 9) < 6);
    s.rm2  = 3'($urandom_range(0, 3));
    s.rn2  = 3'($urandom_range(0, 3));
    s.ld   = ($urandom_range(0, 9) < 4);
    s.exrd = 3'($urandom_range(0, 3));
    s.br   = ($urandom_range(0, 99) < 8);
    return s;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    cur = s;
    #2;
    for (int g = 0; g < 3; g++) mstep(LLV[g], FCV[g], s, m[g], mexp[g]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) m[g] = '{0, 0, 1'b0};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [$];
    stim_t S_IDLE, S_LU, S_LR0, S_RAW, S_BR, S_SLU, S_SM, S_LR, S_NW;
    checks = 0;
    fails  = 0;
    S_IDLE = '0;
    S_LU   = mks(1, 0, 3, 0, 0, 0, 0, 0, 1, 3, 0);
    S_LR0  = mks(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    S_RAW  = mks(1, 1, 1, 2, 5, 1, 0, 5, 0, 0, 0);
    S_BR   = mks(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    S_SLU  = mks(1, 1, 0, 0, 5, 1, 4, 5, 1, 4, 0);
    S_SM   = mks(1, 1, 6, 0, 5, 1, 0, 5, 1, 6, 0);
    S_LR   = mks(1, 1, 1, 2, 5, 1, 0, 5, 1, 1, 0);
    S_NW   = mks(1, 1, 1, 2, 5, 0, 0, 5, 0, 0, 0);

    // {state, pc_write, if_id_write, if_id_flush, split_hold, bubble1, bubble2} for A(1,1) B(2,3) C(3,2)
    tbl.push_back('{"lu_c1",   S_LU,   8'h03, 8'h03, 8'h03});
    tbl.push_back('{"lu_c2",   S_IDLE, 8'h30, 8'h43, 8'h43});
    tbl.push_back('{"lu_c3",   S_IDLE, 8'h30, 8'h30, 8'h43});
    tbl.push_back('{"lu_c4",   S_IDLE, 8'h30, 8'h30, 8'h30});
    tbl.push_back('{"ld_r0",   S_LR0,  8'h30, 8'h30, 8'h30});
    tbl.push_back('{"raw_c1",  S_RAW,  8'h15, 8'h15, 8'h15});
    tbl.push_back('{"raw_c2",  S_RAW,  8'hB2, 8'hB2, 8'hB2});
    tbl.push_back('{"raw_c3",  S_IDLE, 8'h30, 8'h30, 8'h30});
    tbl.push_back('{"bos_c1",  S_LU,   8'h03, 8'h03, 8'h03});
    tbl.push_back('{"bos_c2",  S_BR,   8'h3B, 8'h7B, 8'h7B});
    tbl.push_back('{"bos_c3",  S_IDLE, 8'h30, 8'hFB, 8'hFB});
    tbl.push_back('{"bos_c4",  S_IDLE, 8'h30, 8'hFB, 8'h30});
    tbl.push_back('{"bos_c5",  S_IDLE, 8'h30, 8'h30, 8'h30});
    tbl.push_back('{"rl_c1",   S_BR,   8'h3B, 8'h3B, 8'h3B});
    tbl.push_back('{"rl_c2",   S_IDLE, 8'h30, 8'hFB, 8'hFB});
    tbl.push_back('{"rl_c3",   S_BR,   8'h3B, 8'hFB, 8'h3B});
    tbl.push_back('{"rl_c4",   S_IDLE, 8'h30, 8'hFB, 8'hFB});
    tbl.push_back('{"rl_c5",   S_IDLE, 8'h30, 8'hFB, 8'h30});
    tbl.push_back('{"rl_c6",   S_IDLE, 8'h30, 8'h30, 8'h30});
    tbl.push_back('{"slu_c1",  S_RAW,  8'h15, 8'h15, 8'h15});
    tbl.push_back('{"slu_c2",  S_SLU,  8'h83, 8'h83, 8'h83});
    tbl.push_back('{"slu_c3",  S_IDLE, 8'h30, 8'h43, 8'h43});
    tbl.push_back('{"slu_c4",  S_IDLE, 8'h30, 8'h30, 8'h43});
    tbl.push_back('{"slu_c5",  S_IDLE, 8'h30, 8'h30, 8'h30});
    tbl.push_back('{"sm_c1",   S_RAW,  8'h15, 8'h15, 8'h15});
    tbl.push_back('{"sm_c2",   S_SM,   8'hB2, 8'hB2, 8'hB2});
    tbl.push_back('{"sm_c3",   S_IDLE, 8'h30, 8'h30, 8'h30});
    tbl.push_back('{"pri_c1",  S_LR,   8'h03, 8'h03, 8'h03});
    tbl.push_back('{"pri_c2",  S_IDLE, 8'h30, 8'h43, 8'h43});
    tbl.push_back('{"pri_c3",  S_IDLE, 8'h30, 8'h30, 8'h43});
    tbl.push_back('{"pri_c4",  S_IDLE, 8'h30, 8'h30, 8'h30});
    tbl.push_back('{"sbr_c1",  S_RAW,  8'h15, 8'h15, 8'h15});
    tbl.push_back('{"sbr_c2",  S_BR,   8'hBB, 8'hBB, 8'hBB});
    tbl.push_back('{"sbr_c3",  S_IDLE, 8'h30, 8'hFB, 8'hFB});
    tbl.push_back('{"sbr_c4",  S_IDLE, 8'h30, 8'hFB, 8'h30});
    tbl.push_back('{"sbr_c5",  S_IDLE, 8'h30, 8'h30, 8'h30});
    tbl.push_back('{"no_wr",   S_NW,   8'h30, 8'h30, 8'h30});

    cur   = S_IDLE;
    rst_n = 1'b0;
`ifdef HAZARD_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) check($sformatf("reset_state%0d", g), obs[g], 8'h30);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].s);
      check({tbl[i].name, "_A"}, obs[0], tbl[i].ea);
      check({tbl[i].name, "_B"}, obs[1], tbl[i].eb);
      check({tbl[i].name, "_C"}, obs[2], tbl[i].ec);
      tick();
    end

    // asynchronous reset in the middle of a LOAD_LAT=3 stall, load-use inputs still present
    apply(S_LU);
    check("rst_seq_lu", obs[2], 8'h03);
    tick();
    apply(S_LU);
    check("rst_seq_lstall", obs[2], 8'h43);
    rst_n = 1'b0;
    #1;
    check("rst_async_C", obs[2], 8'h30);
    check("rst_async_A", obs[0], 8'h30);
    tick();
    check("rst_hold_C", obs[2], 8'h30);
    cur   = S_IDLE;
    rst_n = 1'b1;
    model_reset();
    apply(S_IDLE);
    check("rst_release_C", obs[2], 8'h30);
    tick();

`ifdef HAZARD_STATS_EN
    stats_clr = 1'b1;
    apply(S_IDLE);
    tick();
    stats_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply(S_LU);
      tick();
      apply(S_IDLE);
      tick();
    end
    apply(S_BR);
    tick();
    apply(S_IDLE);
    check("stats_stall", st_stall[0], 16'd3);
    check("stats_flush", st_flush[0], 16'd1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    apply(S_IDLE);
    check("stats_clr_stall", st_stall[0], 16'd0);
    check("stats_clr_flush", st_flush[0], 16'd0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
`endif

    for (int n = 0; n < 3000; n++) begin
      apply(rnd_stim());
      for (int g = 0; g < 3; g++) check($sformatf("rand%0d_n%0d", g, n), obs[g], mexp[g]);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
